turn_signal_sequencer: RTL

//  Sequences the rear-lamp datapath (left lamps La/Lb/Lc and right lamps Ra/Rb/Rc)

---
 rtl/turn_signal_sequencer_if.sv | 27 ++
 rtl/turn_signal_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/turn_signal_sequencer_if.sv
// Purpose : Bundles the driver switch requests and the rear-lamp outputs of
//           the turn signal sequencer into one port.
// Signals : left_req/right_req/hazard_req/brake_req  switch levels (async)
//           lamp_l {La,Lb,Lc}, lamp_r {Rc,Rb,Ra}     lamp drivers, bit0 innermost
//           mode (00 idle, 01 left, 10 right, 11 hazard), busy, tick_out
// Modports: master drives requests and watches lamps; slave is the sequencer.
interface turn_signal_sequencer_if;
    logic       left_req;
    logic       right_req;
    logic       hazard_req;
    logic       brake_req;
    logic [2:0] lamp_l;
    logic [2:0] lamp_r;
    logic [1:0] mode;
    logic       busy;
    logic       tick_out;

    modport master (
        output left_req, right_req, hazard_req, brake_req,
        input  lamp_l, lamp_r, mode, busy, tick_out
    );

    modport slave (
        input  left_req, right_req, hazard_req, brake_req,
        output lamp_l, lamp_r, mode, busy, tick_out
    );
endinterface

// File: rtl/turn_signal_sequencer.sv
// Purpose : Rear-lamp sequencer. Synchronizes the driver switches, divides the
//           clock down to an animation step, arbitrates left/right/hazard/brake
//           and walks a 4-phase blink pattern on the selected side(s).
// Ports   : clk    system clock, rising edge
//           reset  synchronous, active-low; clears every flop
//           bus    turn_signal_sequencer_if.slave (requests in, lamps out)
//
// state  | meaning
// IDLE   | no turn animation; lamps show brake only
// LEFT   | left side animates, right side shows brake
// RIGHT  | right side animates, left side shows brake
// HAZARD | both sides animate together, brake ignored
// phase 0 is the off gap; phases 1..3 light 1, 2, 3 lamps from the inside out.
module turn_signal_sequencer #(
    parameter int TICK_DIV = 12_500_000
) (
    input logic                    clk,
    input logic                    reset,
    turn_signal_sequencer_if.slave bus
);
    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_e;

    // bit order: {brake, hazard, right, left}
    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       lamp_l_q, lamp_l_d;
    logic [2:0]       lamp_r_q, lamp_r_d;
    logic             busy_q, busy_d;

    logic left_s, right_s, brake_s, haz_s;
    logic [2:0] pattern, brk;

    assign left_s  = sync2_q[0];
    assign right_s = sync2_q[1];
    assign brake_s = sync2_q[3];
    // both turn switches at once is treated as a hazard request
    assign haz_s   = sync2_q[2] | (sync2_q[0] & sync2_q[1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            mode_q   <= IDLE;
            phase_q  <= 2'd0;
            lamp_l_q <= 3'b000;
            lamp_r_q <= 3'b000;
            busy_q   <= 1'b0;
        end else begin
            sync1_q  <= {bus.brake_req, bus.hazard_req, bus.right_req, bus.left_req};
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            lamp_l_q <= lamp_l_d;
            lamp_r_q <= lamp_r_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        tick_d  = (cnt_q == CNT_MAX);
        mode_d  = mode_q;
        phase_d = phase_q;

        if (tick_q) begin
            if (phase_q == 2'd0) begin
                // blink boundary: re-arbitrate from scratch
                if (haz_s) begin
                    mode_d  = HAZARD;
                    phase_d = 2'd1;
                end else if (left_s) begin
                    mode_d  = LEFT;
                    phase_d = 2'd1;
                end else if (right_s) begin
                    mode_d  = RIGHT;
                    phase_d = 2'd1;
                end else begin
                    mode_d  = IDLE;
                    phase_d = 2'd0;
                end
            end else begin
                case (mode_q)
                    LEFT: begin
                        if (haz_s) begin
                            mode_d  = HAZARD;
                            phase_d = 2'd1;
                        end else if (!left_s) begin
                            mode_d  = IDLE;
                            phase_d = 2'd0;
                        end else begin
                            phase_d = phase_q + 2'd1;
                        end
                    end
                    RIGHT: begin
                        if (haz_s) begin
                            mode_d  = HAZARD;
                            phase_d = 2'd1;
                        end else if (!right_s) begin
                            mode_d  = IDLE;
                            phase_d = 2'd0;
                        end else begin
                            phase_d = phase_q + 2'd1;
                        end
                    end
                    HAZARD: begin
                        if (!haz_s) begin
                            mode_d  = IDLE;
                            phase_d = 2'd0;
                        end else begin
                            phase_d = phase_q + 2'd1;
                        end
                    end
                    default: begin
                        // IDLE never has a nonzero phase; force it back
                        mode_d  = IDLE;
                        phase_d = 2'd0;
                    end
                endcase
            end
        end

        case (phase_d)
            2'd1:    pattern = 3'b001;
            2'd2:    pattern = 3'b011;
            2'd3:    pattern = 3'b111;
            default: pattern = 3'b000;
        endcase

        // lamps follow brake every clock, not just on ticks
        brk = {3{brake_s}};

        case (mode_d)
            LEFT: begin
                lamp_l_d = pattern;
                lamp_r_d = brk;
            end
            RIGHT: begin
                lamp_l_d = brk;
                lamp_r_d = pattern;
            end
            HAZARD: begin
                lamp_l_d = pattern;
                lamp_r_d = pattern;
            end
            default: begin
                lamp_l_d = brk;
                lamp_r_d = brk;
            end
        endcase

        busy_d = (mode_d != IDLE);
    end

    assign bus.lamp_l   = lamp_l_q;
    assign bus.lamp_r   = lamp_r_q;
    assign bus.mode     = mode_q;
    assign bus.busy     = busy_q;
    assign bus.tick_out = tick_q;
endmodule
